// File: rtl/acc_reg_responder_if.sv
// Bundle of the regfile/forwarding signals between the FPU pivot accelerator
// (master) and the CPU-side register file responder (slave).
interface acc_reg_responder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                         rreq_i;
    logic [2:0][ADDR_W-1:0]       raddr_i;
    logic [2:0][DATA_W-1:0]       rdata_o;
    logic                         rvalid_o;
    logic                         acc_wren_i;
    logic [ADDR_W-1:0]            acc_waddr_i;
    logic [DATA_W-1:0]            acc_wdata_i;
    logic                         cpu_we_i;
    logic [ADDR_W-1:0]            cpu_waddr_i;
    logic [DATA_W-1:0]            cpu_wdata_i;
    logic [DATA_W-1:0]            fwd_data_o;
    logic                         fwd_valid_o;
    logic                         wb_full_o;
    logic                         wb_ovf_o;

    modport master (
        output rreq_i, raddr_i, acc_wren_i, acc_waddr_i, acc_wdata_i,
               cpu_we_i, cpu_waddr_i, cpu_wdata_i,
        input  rdata_o, rvalid_o, fwd_data_o, fwd_valid_o, wb_full_o, wb_ovf_o
    );

    modport slave (
        input  rreq_i, raddr_i, acc_wren_i, acc_waddr_i, acc_wdata_i,
               cpu_we_i, cpu_waddr_i, cpu_wdata_i,
        output rdata_o, rvalid_o, fwd_data_o, fwd_valid_o, wb_full_o, wb_ovf_o
    );
endinterface

// File: rtl/acc_reg_responder.sv
// CPU-side register file responder for the FPU pivot accelerator.
// Serves 3-operand reads (latency 1), arbitrates the single RAM write port
// (CPU first, then FIFO drain, then direct accelerator write), queues losing
// accelerator writes in a small FIFO and forwards CPU writeback data.
// Optional feature: define ACC_RF_ZERO_REG_EN to hardwire register 0 to zero.
// Reset rst_n is asynchronous and active-high.
module acc_reg_responder #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    acc_reg_responder_if.slave   bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] ram_q     [NUM_REGS];
    logic [DATA_W-1:0] ram_d     [NUM_REGS];
    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [ADDR_W-1:0] wb_addr_d [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_d [WB_DEPTH];
    logic [WB_DEPTH-1:0] wb_vld_q, wb_vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2:0][DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic              wb_full_q, wb_full_d;
    logic              wb_ovf_q, wb_ovf_d;

    logic              acc_ok, cpu_ok;
    logic              fifo_empty, fifo_full;
    logic              pop, push, push_eff, drop, direct;
    logic [2:0][DATA_W-1:0] rd_res;

    // Writes to r0 are discarded outright when the zero register is enabled.
`ifdef ACC_RF_ZERO_REG_EN
    assign acc_ok = bus.acc_wren_i && (bus.acc_waddr_i != '0);
    assign cpu_ok = bus.cpu_we_i   && (bus.cpu_waddr_i != '0);
`else
    assign acc_ok = bus.acc_wren_i;
    assign cpu_ok = bus.cpu_we_i;
`endif

    // Write-port arbitration: the CPU owns the port whenever it strobes, even to r0.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(WB_DEPTH));
        pop        = !bus.cpu_we_i && !fifo_empty;
        direct     = acc_ok && !bus.cpu_we_i && fifo_empty;
        push       = acc_ok && (bus.cpu_we_i || !fifo_empty);
        drop       = push && fifo_full && !pop;
        push_eff   = push && !drop;
    end

    // Next-state for RAM, writeback FIFO, status and forwarding registers.
    always_comb begin
        ram_d       = ram_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_vld_d    = wb_vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push_eff) - CNT_W'(pop);
        wb_ovf_d    = wb_ovf_q | drop;
        fwd_valid_d = bus.cpu_we_i;
        fwd_data_d  = bus.cpu_we_i ? bus.cpu_wdata_i : fwd_data_q;

        if (cpu_ok) begin
            ram_d[bus.cpu_waddr_i] = bus.cpu_wdata_i;
        end else if (pop) begin
            if (wb_vld_q[rd_ptr_q]) begin
                ram_d[wb_addr_q[rd_ptr_q]] = wb_data_q[rd_ptr_q];
            end
        end else if (direct) begin
            ram_d[bus.acc_waddr_i] = bus.acc_wdata_i;
        end

        // Queued entries older than this CPU write must not overwrite it later.
        if (cpu_ok) begin
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                if (wb_addr_q[i] == bus.cpu_waddr_i) begin
                    wb_vld_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            wb_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d           = rd_ptr_q + PTR_W'(1);
        end

        // Applied after kill/pop so a same-cycle push (newest data) always survives.
        if (push_eff) begin
            wb_addr_d[wr_ptr_q] = bus.acc_waddr_i;
            wb_data_d[wr_ptr_q] = bus.acc_wdata_i;
            wb_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        wb_full_d = (count_d == CNT_W'(WB_DEPTH));
    end

    // Operand resolution: RAM, then oldest-to-newest FIFO, then CPU, then accelerator.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [PTR_W-1:0]  idx;
        logic [DATA_W-1:0] v;
        rd_res = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            a = bus.raddr_i[k];
            v = ram_q[a];
            for (int unsigned j = 0; j < WB_DEPTH; j++) begin
                idx = rd_ptr_q + PTR_W'(j);
                if ((CNT_W'(j) < count_q) && wb_vld_q[idx] && (wb_addr_q[idx] == a)) begin
                    v = wb_data_q[idx];
                end
            end
            if (cpu_ok && (bus.cpu_waddr_i == a)) begin
                v = bus.cpu_wdata_i;
            end
            if ((push_eff || direct) && (bus.acc_waddr_i == a)) begin
                v = bus.acc_wdata_i;
            end
`ifdef ACC_RF_ZERO_REG_EN
            if (a == '0) begin
                v = '0;
            end
`endif
            rd_res[k] = v;
        end
        rvalid_d = bus.rreq_i;
        rdata_d  = bus.rreq_i ? rd_res : rdata_q;
    end

    // State registers; reset clears RAM, FIFO and any in-flight read.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                ram_q[i] <= '0;
            end
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
            wb_vld_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            fwd_data_q  <= '0;
            fwd_valid_q <= 1'b0;
            wb_full_q   <= 1'b0;
            wb_ovf_q    <= 1'b0;
        end else begin
            ram_q       <= ram_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_vld_q    <= wb_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_valid_q <= fwd_valid_d;
            wb_full_q   <= wb_full_d;
            wb_ovf_q    <= wb_ovf_d;
        end
    end

    assign bus.rdata_o     = rdata_q;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.fwd_data_o  = fwd_data_q;
    assign bus.fwd_valid_o = fwd_valid_q;
    assign bus.wb_full_o   = wb_full_q;
    assign bus.wb_ovf_o    = wb_ovf_q;

endmodule

// File: tb/tb_acc_reg_responder.sv
// Directed bench for acc_reg_responder: a write-order reference memory feeds
// a scoreboard of expected read data, compared when rvalid_o returns.
module tb_acc_reg_responder;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    acc_reg_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    acc_reg_responder #(
        .NUM_REGS(16),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .WB_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic [DW-1:0] model [16];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd [3];
    logic [DW-1:0] last_fwd;

    function automatic bit is_zero_reg(input logic [AW-1:0] a);
`ifdef ACC_RF_ZERO_REG_EN
        return (a == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rreq_i      = 1'b0;
        bus.raddr_i     = '0;
        bus.acc_wren_i  = 1'b0;
        bus.acc_waddr_i = '0;
        bus.acc_wdata_i = '0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_waddr_i = '0;
        bus.cpu_wdata_i = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.rreq_i     = 1'b1;
        bus.raddr_i[0] = a0;
        bus.raddr_i[1] = a1;
        bus.raddr_i[2] = a2;
    endtask

    task automatic accw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.acc_wren_i  = 1'b1;
        bus.acc_waddr_i = a;
        bus.acc_wdata_i = d;
    endtask

    task automatic cpuw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpu_we_i    = 1'b1;
        bus.cpu_waddr_i = a;
        bus.cpu_wdata_i = d;
    endtask

    // One clock: update the reference in presentation order (CPU, then the newer
    // accelerator write unless it is known to be dropped), queue expected reads,
    // then check every output after the edge.
    task automatic tick(input bit drop, input logic exp_full, input logic exp_ovf);
        logic exp_rv;
        logic exp_fv;
        if (bus.cpu_we_i && !is_zero_reg(bus.cpu_waddr_i))
            model[bus.cpu_waddr_i] = bus.cpu_wdata_i;
        if (bus.acc_wren_i && !drop && !is_zero_reg(bus.acc_waddr_i))
            model[bus.acc_waddr_i] = bus.acc_wdata_i;
        exp_rv = bus.rreq_i;
        if (exp_rv) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(model[bus.raddr_i[k]]);
        end
        exp_fv = bus.cpu_we_i;
        if (exp_fv) last_fwd = bus.cpu_wdata_i;
        @(posedge clk);
        #1;
        check("rvalid", DW'(bus.rvalid_o), DW'(exp_rv));
        for (int k = 0; k < 3; k++) begin
            if (exp_rv) last_rd[k] = exp_q.pop_front();
            check($sformatf("rdata[%0d]", k), bus.rdata_o[k], last_rd[k]);
        end
        check("fwd_valid", DW'(bus.fwd_valid_o), DW'(exp_fv));
        check("fwd_data", bus.fwd_data_o, last_fwd);
        check("wb_full", DW'(bus.wb_full_o), DW'(exp_full));
        check("wb_ovf", DW'(bus.wb_ovf_o), DW'(exp_ovf));
        idle();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        last_fwd = '0;
        exp_q.delete();
    endtask

    initial begin
        idle();
        clear_model();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", DW'(bus.rvalid_o), '0);
        check("rst_rdata0", bus.rdata_o[0], '0);
        check("rst_fwd_valid", DW'(bus.fwd_valid_o), '0);
        check("rst_fwd_data", bus.fwd_data_o, '0);
        check("rst_wb_full", DW'(bus.wb_full_o), '0);
        check("rst_wb_ovf", DW'(bus.wb_ovf_o), '0);
        rst_n = 1'b0;

        // Read of freshly reset registers
        rd(0, 1, 2);                        tick(0, 0, 0);
        tick(0, 0, 0);                      // rdata hold while idle

        // Direct accelerator write with empty FIFO
        accw(1, 32'h4040_0000);             tick(0, 0, 0);
        rd(1, 1, 1);                        tick(0, 0, 0);

        // CPU/accelerator collision with bypass read, then drain
        cpuw(2, 32'h3F80_0000);
        accw(7, 32'h4150_0000);
        rd(7, 2, 1);                        tick(0, 0, 0);
        tick(0, 0, 0);
        rd(7, 2, 7);                        tick(0, 0, 0);

        // Queued write killed by a later CPU write to the same register
        cpuw(5, 32'h0000_0055);
        accw(3, 32'h1111_1111);
        rd(3, 5, 3);                        tick(0, 0, 0);
        cpuw(3, 32'h2222_2222);
        rd(3, 3, 3);                        tick(0, 0, 0);
        tick(0, 0, 0);
        rd(3, 5, 3);                        tick(0, 0, 0);

        // Fill to full under a held CPU write; fifth accelerator write dropped
        for (int i = 0; i < 5; i++) begin
            cpuw(9, DW'(32'h900 + i));
            accw(AW'(10 + i), DW'(32'hA0 + i));
            tick(i == 4, i >= 3, i == 4);
        end
        rd(10, 11, 12);                     tick(0, 0, 1);
        rd(10, 11, 12);                     tick(0, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
        rd(13, 14, 10);                     tick(0, 0, 1);

        // Second fill: same-address entries resolve to the newest; push while full and popping
        cpuw(9, 32'h0000_0B00); accw(11, 32'h0000_00B0); tick(0, 0, 1);
        cpuw(9, 32'h0000_0B01); accw(11, 32'h0000_00B1); tick(0, 0, 1);
        cpuw(9, 32'h0000_0B02); accw(12, 32'h0000_00B2); tick(0, 0, 1);
        cpuw(9, 32'h0000_0B03); accw(13, 32'h0000_00B3);
        rd(11, 13, 9);                                   tick(0, 1, 1);
        accw(15, 32'h0000_00C0);
        rd(11, 15, 12);                                  tick(0, 1, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 1);
        rd(11, 12, 15);                     tick(0, 0, 1);
        rd(13, 9, 10);                      tick(0, 0, 1);

        // Register 0 writes from CPU and accelerator
        cpuw(0, 32'hDEAD_BEEF);             tick(0, 0, 1);
        rd(0, 0, 1);                        tick(0, 0, 1);
        accw(0, 32'h1234_5678);             tick(0, 0, 1);
        rd(0, 2, 0);                        tick(0, 0, 1);

        // Reset mid-operation with a queued write and a pending read
        cpuw(9, 32'h0000_0099);
        accw(4, 32'h0000_0077);             tick(0, 0, 1);
        rd(4, 9, 4);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_rvalid", DW'(bus.rvalid_o), '0);
        check("midrst_rdata1", bus.rdata_o[1], '0);
        check("midrst_fwd_valid", DW'(bus.fwd_valid_o), '0);
        check("midrst_wb_ovf", DW'(bus.wb_ovf_o), '0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_model();
        tick(0, 0, 0);
        rd(4, 9, 1);                        tick(0, 0, 0);

        check("scoreboard_drained", DW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
